read_id_tracker: RTL and testbench
==================================

# read_id_tracker

Sits directly downstream of the AR-side read ID generator. It consumes R-channel responses that carry the extended ID `{seq, id}` and checks each response against the expected per-ID sequence. It strips the sequence field, forwards the beat to the master through a 2-entry skid buffer, and tracks outstanding reads per base ID. The AR handshake is throttled per ID so sequence numbers can never alias.

## Interface
Parameters:
- `ID_PAD`, default 4: sequence field width; must match the generator.
- `ID_WIDTH`, default 2: base ID width; the block tracks 2^ID_WIDTH IDs.
- `DATA_WIDTH`, default 32: R data width.
- `MAX_OUTST`, default 8: maximum outstanding reads per ID. Legal range is 1 to 2^ID_PAD-1.

Ports:
- `Aclk` in, 1: clock. All state updates on its rising edge.
- `ARESETnRst` in, 1: asynchronous active-low reset.
- `AR_ID` in, ID_WIDTH: base ID of the current AR request.
- `AR_valid_in` in, 1: AR valid from the master.
- `AR_Ready_in` in, 1: AR ready from the slave side.
- `AR_valid_out` in the outbound direction (out), 1: AR valid to the slave side, gated.
- `AR_Ready_out` out, 1: AR ready to the master, gated.
- `R_ID_in` in, ID_WIDTH+ID_PAD: extended RID from the slave.
- `R_data_in` in, DATA_WIDTH: read data from the slave.
- `R_resp_in` in, 2: read response from the slave.
- `R_last_in` in, 1: last-beat flag from the slave.
- `R_valid_in` in, 1: R valid from the slave.
- `R_Ready_out` out, 1: R ready to the slave.
- `R_ID_out` out, ID_WIDTH: base RID to the master, equal to `R_ID_in[ID_WIDTH-1:0]`.
- `R_data_out` out, DATA_WIDTH: read data to the master.
- `R_resp_out` out, 2: read response to the master.
- `R_last_out` out, 1: last-beat flag to the master.
- `R_valid_out` out, 1: R valid to the master.
- `R_Ready_in` in, 1: R ready from the master.
- `seq_err` out, 1: one-cycle registered error pulse.
- `err_id` out, ID_WIDTH: base ID of the most recent error.
- `err_cnt` out, 8: error count, saturating at 255.
- `busy` out, 1: high when any outstanding count is nonzero.

## Operation
- Reset behaviour:
  - All outstanding counts `outst[i]` and expected sequence numbers `exp_seq[i]` reset to 0.
  - The skid buffer is emptied.
  - Outputs at reset: `R_valid_out`=0, `R_Ready_out`=1, `seq_err`=0, `err_id`=0, `err_cnt`=0, `busy`=0.
- AR gating is combinational:
  - `full = (outst[AR_ID] == MAX_OUTST)`.
  - `AR_valid_out = AR_valid_in & ~full`.
  - `AR_Ready_out = AR_Ready_in & ~full`.
  - An AR handshake (`arhs`) is `AR_valid_in & AR_Ready_in & ~full`.
- Input R acceptance (`rin`) is `R_valid_in & R_Ready_out`. Each accepted beat is split into `s = R_ID_in[ID_WIDTH+ID_PAD-1:ID_WIDTH]` and `b = R_ID_in[ID_WIDTH-1:0]`.
- Sequence check, applied on every accepted beat:
  - The beat is an error if `s != exp_seq[b]` or `outst[b] == 0`.
  - On error, next cycle: `seq_err`=1, `err_id`=b, and `err_cnt` increments (saturating).
  - The errored beat is still forwarded unchanged.
- On an accepted beat with `R_last_in`=1:
  - `exp_seq[b]` increments, modulo 2^ID_PAD, so 15 wraps to 0 at the default width.
  - `outst[b]` decrements, but only if it is nonzero.
- Outstanding-count update:
  - `arhs` increments `outst[AR_ID]`.
  - When `arhs` and an R last beat hit the same ID in the same cycle, that count is unchanged.
  - When they hit different IDs, each count updates independently.
- Skid buffer:
  - 2 entries, FIFO order, each holding `{b, data, resp, last}`.
  - `R_Ready_out = (occupancy != 2)`, driven from a register.
  - The head entry drives the `R_*_out` outputs.
  - `R_valid_out = (occupancy != 0)`.
  - A pop occurs when `R_valid_out & R_Ready_in`.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Output payload is stable while `R_valid_out=1 & R_Ready_in=0`.
- `busy` is registered: the OR of all `outst[i] != 0`.
- Asserting reset mid-burst drops buffered beats and clears all counters immediately, asynchronously.

## Timing
- R path latency is 1 cycle: a beat accepted at edge N appears on `R_*_out` after edge N, provided the buffer was empty.
- Sustained throughput is 1 beat per cycle when `R_Ready_in` is held at 1.
- The `seq_err` pulse occurs in the cycle after the offending acceptance, aligned with that beat's first appearance on the output.
- AR gating has zero latency. `full` reflects counts as of the previous edge, so the `arhs` that reaches `MAX_OUTST` blocks the next request for that ID in the following cycle.
- No combinational path exists from `R_Ready_in` to `R_Ready_out`.

## Test plan
- Issue 3 ARs on ID 1, then return 3 single-beat R responses with seq 0, 1, 2 -> expected outputs:
  - `R_ID_out`=1 for each beat.
  - `seq_err` never asserts.
  - `outst[1]` ends at 0 and `busy` drops to 0.
- Issue 8 ARs on ID 2 with `MAX_OUTST`=8, then raise a 9th request -> required response:
  - `AR_Ready_out`=0 and `AR_valid_out`=0 for the 9th request.
  - An R last beat for ID 2 re-enables both the next cycle.
- Outstanding reads on ID 0 with expected seq 0, then return a beat with seq 3 -> required response:
  - `seq_err` pulses 1 cycle later with `err_id`=0 and `err_cnt`=1.
  - The beat is still forwarded.
- Return an R beat for ID 3 with no outstanding reads -> `seq_err` pulses, `err_cnt` increments, and `outst[3]` stays at 0.
- Run 16 complete single-beat reads on ID 1 -> `exp_seq[1]` wraps from 15 to 0, and the 17th read with seq 0 raises no error.
- Stream a 4-beat burst with `R_Ready_in` held low for 3 cycles -> required response:
  - `R_Ready_out` drops after 2 beats are accepted.
  - No beat is lost or reordered.
  - Asserting reset mid-burst clears `R_valid_out` immediately.

Source files
------------

// File: rtl/read_id_tracker.sv
// -----------------------------------------------------------------------------
// read_id_tracker
//
// Purpose:
//   Receives R-channel beats tagged with the extended ID {seq, id} that the
//   upstream read ID generator produced, checks each beat's sequence field
//   against the sequence number expected for its base ID, strips the
//   sequence field and hands the beat to the master through a 2-entry skid
//   buffer. It also counts outstanding reads per base ID and blocks further
//   AR requests on an ID once MAX_OUTST reads are in flight, so the sequence
//   field can never alias.
//
// Ports:
//   Aclk, ARESETnRst          clock, asynchronous active-low reset
//   AR_ID                     base ID of the current AR request
//   AR_valid_in/AR_Ready_in   AR handshake inputs (master valid, slave ready)
//   AR_valid_out/AR_Ready_out AR handshake outputs, gated by the per-ID limit
//   R_ID_in .. R_valid_in     R beat from the slave, extended ID
//   R_Ready_out               R ready to the slave (registered)
//   R_ID_out .. R_valid_out   R beat to the master, base ID only
//   R_Ready_in                R ready from the master
//   seq_err                   one-cycle pulse for a mismatched or unexpected beat
//   err_id                    base ID of the most recent error
//   err_cnt                   saturating error count
//   busy                      any ID has outstanding reads (registered)
// -----------------------------------------------------------------------------
module read_id_tracker #(
  parameter int ID_PAD     = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 8
) (
  input  logic                         Aclk,
  input  logic                         ARESETnRst,
  input  logic [ID_WIDTH-1:0]          AR_ID,
  input  logic                         AR_valid_in,
  input  logic                         AR_Ready_in,
  output logic                         AR_valid_out,
  output logic                         AR_Ready_out,
  input  logic [ID_WIDTH+ID_PAD-1:0]   R_ID_in,
  input  logic [DATA_WIDTH-1:0]        R_data_in,
  input  logic [1:0]                   R_resp_in,
  input  logic                         R_last_in,
  input  logic                         R_valid_in,
  output logic                         R_Ready_out,
  output logic [ID_WIDTH-1:0]          R_ID_out,
  output logic [DATA_WIDTH-1:0]        R_data_out,
  output logic [1:0]                   R_resp_out,
  output logic                         R_last_out,
  output logic                         R_valid_out,
  input  logic                         R_Ready_in,
  output logic                         seq_err,
  output logic [ID_WIDTH-1:0]          err_id,
  output logic [7:0]                   err_cnt,
  output logic                         busy
);

  localparam int NID = 1 << ID_WIDTH;
  localparam int XW  = ID_WIDTH + ID_PAD;
  localparam int EW  = ID_WIDTH + DATA_WIDTH + 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Per-ID tracking state
  logic [ID_PAD-1:0] outst_q   [NID];
  logic [ID_PAD-1:0] outst_d   [NID];
  logic [ID_PAD-1:0] exp_seq_q [NID];
  logic [ID_PAD-1:0] exp_seq_d [NID];
  logic              ar_hit    [NID];
  logic              rl_hit    [NID];
  logic              busy_q, busy_d;

  // Error reporting state
  logic                seq_err_q;
  logic [ID_WIDTH-1:0] err_id_q;
  logic [7:0]          err_cnt_q;

  // Skid buffer state
  logic [EW-1:0] mem_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          rready_q;

  logic                full, arhs, rin, err, push, pop;
  logic [ID_PAD-1:0]   s;
  logic [ID_WIDTH-1:0] b;
  logic [EW-1:0]       head;

  // AR gating: full is based on registered counts, so the handshake that
  // fills an ID only blocks that ID from the following cycle on.
  assign full         = (outst_q[AR_ID] == ID_PAD'(MAX_OUTST));
  assign AR_valid_out = AR_valid_in & ~full;
  assign AR_Ready_out = AR_Ready_in & ~full;
  assign arhs         = AR_valid_in & AR_Ready_in & ~full;

  assign rin = R_valid_in & rready_q;
  assign s   = R_ID_in[XW-1:ID_WIDTH];
  assign b   = R_ID_in[ID_WIDTH-1:0];

  // A beat is unexpected if its sequence does not match or nothing is
  // outstanding on its ID; it is still forwarded.
  assign err = rin & ((s != exp_seq_q[b]) | (outst_q[b] == '0));

  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NID; i++) begin
      ar_hit[i]    = arhs & (AR_ID == ID_WIDTH'(i));
      rl_hit[i]    = rin & R_last_in & (b == ID_WIDTH'(i));
      outst_d[i]   = outst_q[i];
      exp_seq_d[i] = exp_seq_q[i];
      // AR and last beat on the same ID cancel out.
      if (ar_hit[i] && !rl_hit[i]) begin
        outst_d[i] = outst_q[i] + 1'b1;
      end else if (rl_hit[i] && !ar_hit[i] && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - 1'b1;
      end
      // Sequence field wraps naturally at 2^ID_PAD.
      if (rl_hit[i]) begin
        exp_seq_d[i] = exp_seq_q[i] + 1'b1;
      end
      busy_d = busy_d | (outst_d[i] != '0);
    end
  end

  always_ff @(posedge Aclk or negedge ARESETnRst) begin
    if (!ARESETnRst) begin
      for (int i = 0; i < NID; i++) begin
        outst_q[i]   <= '0;
        exp_seq_q[i] <= '0;
      end
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NID; i++) begin
        outst_q[i]   <= outst_d[i];
        exp_seq_q[i] <= exp_seq_d[i];
      end
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge Aclk or negedge ARESETnRst) begin
    if (!ARESETnRst) begin
      seq_err_q <= 1'b0;
      err_id_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      seq_err_q <= err;
      if (err) begin
        err_id_q  <= b;
        err_cnt_q <= sat_inc8(err_cnt_q);
      end
    end
  end

  // Skid buffer: ready is registered from the next occupancy, so there is
  // no combinational path from R_Ready_in to R_Ready_out.
  assign push = rin;
  assign pop  = (cnt_q != 2'd0) & R_Ready_in;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Aclk or negedge ARESETnRst) begin
    if (!ARESETnRst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q    <= cnt_d;
      rready_q <= (cnt_d != 2'd2);
    end
  end

  always_ff @(posedge Aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {b, R_data_in, R_resp_in, R_last_in};
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign {R_ID_out, R_data_out, R_resp_out, R_last_out} = head;
  assign R_valid_out = (cnt_q != 2'd0);
  assign R_Ready_out = rready_q;

  assign seq_err = seq_err_q;
  assign err_id  = err_id_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_read_id_tracker.sv
module tb_read_id_tracker;

  logic        Aclk = 1'b0;
  logic        ARESETnRst;
  logic [1:0]  AR_ID;
  logic        AR_valid_in, AR_Ready_in, AR_valid_out, AR_Ready_out;
  logic [5:0]  R_ID_in;
  logic [31:0] R_data_in;
  logic [1:0]  R_resp_in;
  logic        R_last_in, R_valid_in, R_Ready_out;
  logic [1:0]  R_ID_out;
  logic [31:0] R_data_out;
  logic [1:0]  R_resp_out;
  logic        R_last_out, R_valid_out, R_Ready_in;
  logic        seq_err;
  logic [1:0]  err_id;
  logic [7:0]  err_cnt;
  logic        busy;

  int tests = 0;
  int fails = 0;

  read_id_tracker #(.ID_PAD(4), .ID_WIDTH(2), .DATA_WIDTH(32), .MAX_OUTST(8)) dut (
    .Aclk(Aclk), .ARESETnRst(ARESETnRst),
    .AR_ID(AR_ID), .AR_valid_in(AR_valid_in), .AR_Ready_in(AR_Ready_in),
    .AR_valid_out(AR_valid_out), .AR_Ready_out(AR_Ready_out),
    .R_ID_in(R_ID_in), .R_data_in(R_data_in), .R_resp_in(R_resp_in),
    .R_last_in(R_last_in), .R_valid_in(R_valid_in), .R_Ready_out(R_Ready_out),
    .R_ID_out(R_ID_out), .R_data_out(R_data_out), .R_resp_out(R_resp_out),
    .R_last_out(R_last_out), .R_valid_out(R_valid_out), .R_Ready_in(R_Ready_in),
    .seq_err(seq_err), .err_id(err_id), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 Aclk = ~Aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Aclk);
    #1;
  endtask

  task automatic ar(input logic [1:0] id);
    AR_ID = id; AR_valid_in = 1'b1; AR_Ready_in = 1'b1;
    tick();
    AR_valid_in = 1'b0; AR_Ready_in = 1'b0;
  endtask

  task automatic drive_r(input logic [3:0] sq, input logic [1:0] id,
                         input logic [31:0] d, input logic last);
    R_ID_in = {sq, id}; R_data_in = d; R_resp_in = 2'b00;
    R_last_in = last; R_valid_in = 1'b1;
  endtask

  task automatic rbeat(input logic [3:0] sq, input logic [1:0] id, input logic [31:0] d);
    drive_r(sq, id, d, 1'b1);
    tick();
    R_valid_in = 1'b0;
  endtask

  initial begin
    ARESETnRst = 1'b0;
    AR_ID = '0; AR_valid_in = 0; AR_Ready_in = 0;
    R_ID_in = '0; R_data_in = '0; R_resp_in = '0; R_last_in = 0; R_valid_in = 0;
    R_Ready_in = 1'b1;

    // Reset state
    #12;
    chk("rst_rvalid", R_valid_out, 1'b0);
    chk("rst_rready", R_Ready_out, 1'b1);
    chk("rst_seqerr", seq_err, 1'b0);
    chk("rst_errid", err_id, 2'd0);
    chk("rst_errcnt", err_cnt, 8'd0);
    chk("rst_busy", busy, 1'b0);
    ARESETnRst = 1'b1;

    // Three reads on ID 1, in-order responses
    ar(2'd1);
    chk("t1_busy_up", busy, 1'b1);
    ar(2'd1);
    ar(2'd1);
    for (int k = 0; k < 3; k++) begin
      rbeat(4'(k), 2'd1, 32'hA000_0000 + 32'(k));
      chk("t1_rvalid", R_valid_out, 1'b1);
      chk("t1_rid", R_ID_out, 2'd1);
      chk("t1_rdata", R_data_out, 32'hA000_0000 + 32'(k));
      chk("t1_seqerr", seq_err, 1'b0);
    end
    chk("t1_busy_down", busy, 1'b0);
    tick();
    chk("t1_drained", R_valid_out, 1'b0);

    // Eight reads on ID 2 fill it; a ninth is blocked
    for (int k = 0; k < 8; k++) ar(2'd2);
    AR_ID = 2'd2; AR_valid_in = 1'b1; AR_Ready_in = 1'b1;
    #1;
    chk("t2_full_ready", AR_Ready_out, 1'b0);
    chk("t2_full_valid", AR_valid_out, 1'b0);
    AR_ID = 2'd3;
    #1;
    chk("t2_other_id_ready", AR_Ready_out, 1'b1);
    AR_ID = 2'd2;
    drive_r(4'd0, 2'd2, 32'hB000_0000, 1'b1);
    tick();
    R_valid_in = 1'b0;
    chk("t2_reopen_ready", AR_Ready_out, 1'b1);
    chk("t2_reopen_valid", AR_valid_out, 1'b1);
    AR_valid_in = 1'b0; AR_Ready_in = 1'b0;
    for (int k = 1; k < 8; k++) begin
      rbeat(4'(k), 2'd2, 32'hB000_0000 + 32'(k));
      chk("t2_drain_seqerr", seq_err, 1'b0);
    end
    tick();
    chk("t2_busy_down", busy, 1'b0);

    // Wrong sequence on ID 0
    ar(2'd0);
    rbeat(4'd3, 2'd0, 32'hDEAD_0003);
    chk("t3_seqerr", seq_err, 1'b1);
    chk("t3_errid", err_id, 2'd0);
    chk("t3_errcnt", err_cnt, 8'd1);
    chk("t3_fwd_valid", R_valid_out, 1'b1);
    chk("t3_fwd_id", R_ID_out, 2'd0);
    chk("t3_fwd_data", R_data_out, 32'hDEAD_0003);
    tick();
    chk("t3_pulse_end", seq_err, 1'b0);
    chk("t3_errcnt_hold", err_cnt, 8'd1);

    // Beat on ID 3 with nothing outstanding
    rbeat(4'd0, 2'd3, 32'hC0DE_0003);
    chk("t4_seqerr", seq_err, 1'b1);
    chk("t4_errid", err_id, 2'd3);
    chk("t4_errcnt", err_cnt, 8'd2);
    chk("t4_fwd_data", R_data_out, 32'hC0DE_0003);
    tick();
    chk("t4_busy", busy, 1'b0);
    chk("t4_pulse_end", seq_err, 1'b0);

    // Sequence wrap on ID 1 from a clean reset
    ARESETnRst = 1'b0;
    #3;
    ARESETnRst = 1'b1;
    chk("t5_errcnt_rst", err_cnt, 8'd0);
    for (int k = 0; k < 16; k++) begin
      ar(2'd1);
      rbeat(4'(k), 2'd1, 32'h5000_0000 + 32'(k));
      chk("t5_seqerr", seq_err, 1'b0);
      chk("t5_rdata", R_data_out, 32'h5000_0000 + 32'(k));
    end
    ar(2'd1);
    rbeat(4'd0, 2'd1, 32'h5000_0010);
    chk("t5_wrap_seqerr", seq_err, 1'b0);
    chk("t5_wrap_errcnt", err_cnt, 8'd0);
    tick();

    // 4-beat burst with master stalled for 3 cycles
    ar(2'd0);
    R_Ready_in = 1'b0;
    drive_r(4'd0, 2'd0, 32'hD000_0000, 1'b0);
    tick();
    chk("t6_rready_1", R_Ready_out, 1'b1);
    chk("t6_head_1", R_data_out, 32'hD000_0000);
    drive_r(4'd0, 2'd0, 32'hD000_0001, 1'b0);
    tick();
    chk("t6_rready_full", R_Ready_out, 1'b0);
    chk("t6_head_2", R_data_out, 32'hD000_0000);
    drive_r(4'd0, 2'd0, 32'hD000_0002, 1'b0);
    tick();
    chk("t6_rready_stall", R_Ready_out, 1'b0);
    chk("t6_head_stable", R_data_out, 32'hD000_0000);
    chk("t6_last_0", R_last_out, 1'b0);
    R_Ready_in = 1'b1;
    tick();
    chk("t6_head_b1", R_data_out, 32'hD000_0001);
    chk("t6_rready_reopen", R_Ready_out, 1'b1);
    tick();
    chk("t6_head_b2", R_data_out, 32'hD000_0002);
    drive_r(4'd0, 2'd0, 32'hD000_0003, 1'b1);
    tick();
    R_valid_in = 1'b0;
    R_Ready_in = 1'b0;
    chk("t6_head_b3", R_data_out, 32'hD000_0003);
    chk("t6_last_3", R_last_out, 1'b1);
    chk("t6_seqerr", seq_err, 1'b0);
    chk("t6_busy", busy, 1'b0);
    tick();
    chk("t6_held_valid", R_valid_out, 1'b1);
    #3;
    ARESETnRst = 1'b0;
    #1;
    chk("t6_rst_rvalid", R_valid_out, 1'b0);
    chk("t6_rst_rready", R_Ready_out, 1'b1);
    ARESETnRst = 1'b1;
    R_Ready_in = 1'b1;
    tick();
    chk("t6_post_rst_rvalid", R_valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
